yon_motor_surucu: RTL and testbench
===================================

Name: yon_motor_surucu

Overview:
- Downstream stage of the obstacle/direction logic. Consumes the 2-bit direction code (yon_solbit, yon_sagbit) and drives the left and right motor forward/reverse enables.
- Filters code glitches with a stability window.
- Enforces a brake (dead-time) interval on every direction change, so a motor never switches directly between drive commands.

Parameters:
- KARARLI_SAYI, 4: consecutive identical samples required before a code is accepted; must be ≥1.
- OLU_ZAMAN, 8: brake duration in clock cycles on any direction change or disable; must be ≥1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- etkin, input, 1: drive enable.
- yon_solbit, input, 1: direction code MSB, from the upstream direction logic.
- yon_sagbit, input, 1: direction code LSB, from the upstream direction logic.
- sol_ileri, output, 1: left motor forward.
- sol_geri, output, 1: left motor reverse.
- sag_ileri, output, 1: right motor forward.
- sag_geri, output, 1: right motor reverse.
- aktif_yon, output, 2: code currently being driven; {solbit, sagbit}.
- mesgul, output, 1: high while in FREN.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Code and motor mapping, yon = {yon_solbit, yon_sagbit}:
  - 00 DUZ: sol_ileri=1, sag_ileri=1.
  - 10 SAGA: sol_ileri=1, right motor off.
  - 01 SOLA: sag_ileri=1, left motor off.
  - 11 GERI: sol_geri=1, sag_geri=1.
- Stability filter, with registers aday[1:0] and sayac:
  - If yon != aday: aday<=yon, sayac<=0.
  - Else if sayac < KARARLI_SAYI-1: sayac++.
  - kararli = (sayac == KARARLI_SAYI-1), evaluated from registered values.
  - Reset sets aday=00, sayac=0; reset counts as the first sample of 00.
  - Any mismatch restarts the window. Glitches shorter than KARARLI_SAYI samples are never seen by the FSM.
- FSM states DUR, SUR, FREN; reset state is DUR.
  - DUR: all motor outputs 0. If etkin && kararli: aktif_yon<=aday, go to SUR.
  - SUR: motors driven from aktif_yon per the mapping.
    - If !etkin: go to FREN.
    - Else if kararli && aday != aktif_yon: go to FREN.
    - Otherwise stay in SUR.
  - FREN: all motor outputs 0, mesgul=1.
    - The brake counter is loaded with OLU_ZAMAN-1 on entry and decrements each cycle; FREN lasts exactly OLU_ZAMAN cycles.
    - At count 0: if etkin && kararli, aktif_yon<=aday (newest stable code, even if it changed during FREN) and go to SUR; else go to DUR.
    - FREN is never aborted early, except by rst.
- Outputs:
  - Motor outputs are a decode of the registered state and aktif_yon: valid the cycle after the state edge, no input-to-output combinational path.
  - mesgul = (state == FREN).
  - aktif_yon holds its last value in DUR and FREN. Reset value is 00.
  - Reset values: all motor outputs 0, mesgul 0.
- Invariant, checked by assertion every cycle: never (x_ileri && x_geri) for either motor.
- Latency: a code presented before edge 1 is accepted after edge KARARLI_SAYI and driven after edge KARARLI_SAYI+1. This holds from DUR, and from SUR when the code is unchanged.
- Reset mid-operation: next edge gives DUR with all outputs 0. No dead time is applied, because the motors are already off.
- etkin falling in DUR has no effect. etkin rising in FREN does not shorten the brake.

Decomposition:
- Shared package yon_pkg:
  - Code constants YON_DUZ=2'b00, YON_SOLA=2'b01, YON_SAGA=2'b10, YON_GERI=2'b11.
  - FSM state encoding DUR, SUR, FREN (2 bits).
- One sub-module, yon_kararlilik_filtresi:
  - Parameter KARARLI_SAYI.
  - Ports clk, rst, yon[1:0], aday[1:0], kararli.
- The FSM, brake counter and output decode stay in the top module.

Test Plan (KARARLI_SAYI=4, OLU_ZAMAN=8):
1. rst 1 cycle, then etkin=1, yon=00 held -> kararli after edge 3, state SUR after edge 4, sol_ileri=sag_ileri=1, aktif_yon=00, mesgul=0.
2. In SUR with 00, drive yon=11 for 3 cycles, then 00 -> never FREN, outputs unchanged, mesgul stays 0.
3. In SUR with 00, yon=11 held -> FREN entered 4 edges after the change; 8 cycles of all motors 0 and mesgul=1; then sol_geri=sag_geri=1, aktif_yon=11.
4. Start 3, but switch yon to 10 during FREN cycle 2 and hold -> exit to SUR with aktif_yon=10, sol_ileri=1, sag_*=0.
5. In SUR, etkin=0 -> FREN for 8 cycles, then DUR. etkin=1 with a stable code -> SUR on the next edge.
6. rst asserted during FREN cycle 3 -> after that edge: DUR, all motor outputs 0, mesgul=0, aktif_yon=00. Forward/reverse overlap assertion never fires in any test.

Source files
------------

// File: rtl/yon_pkg.sv
// yon_pkg: direction codes, FSM states and motor decode
// shared by the motor driver stage.
package yon_pkg;

    localparam logic [1:0] YON_DUZ  = 2'b00;
    localparam logic [1:0] YON_SOLA = 2'b01;
    localparam logic [1:0] YON_SAGA = 2'b10;
    localparam logic [1:0] YON_GERI = 2'b11;

    typedef enum logic [1:0] {
        DUR  = 2'b00,
        SUR  = 2'b01,
        FREN = 2'b10
    } durum_t;

    // {sol_ileri, sol_geri, sag_ileri, sag_geri}
    function automatic logic [3:0] motor_coz(input logic [1:0] yon);
        logic [3:0] m;
        m = 4'b0000;
        unique case (yon)
            YON_DUZ:  m = 4'b1010;
            YON_SAGA: m = 4'b1000;
            YON_SOLA: m = 4'b0010;
            YON_GERI: m = 4'b0101;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/yon_kararlilik_filtresi.sv
// yon_kararlilik_filtresi: accepts a direction code only
// after KARARLI_SAYI identical consecutive samples.
module yon_kararlilik_filtresi
    import yon_pkg::*;
#(
    parameter int KARARLI_SAYI = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] yon,
    output logic [1:0] aday,
    output logic       kararli
);

    localparam int SW = (KARARLI_SAYI > 1) ? $clog2(KARARLI_SAYI) : 1;
    localparam logic [SW-1:0] SON = SW'(KARARLI_SAYI - 1);

    logic [SW-1:0] sayac;

    // reset itself counts as the first sample of DUZ
    always_ff @(posedge clk) begin
        if (rst) begin
            aday  <= YON_DUZ;
            sayac <= '0;
        end else if (yon != aday) begin
            aday  <= yon;
            sayac <= '0;
        end else if (sayac < SON) begin
            sayac <= sayac + 1'b1;
        end
    end

    assign kararli = (sayac == SON);

endmodule

// File: rtl/yon_motor_surucu.sv
// yon_motor_surucu: filtered direction code to motor enables,
// with a fixed brake interval on every direction change.
module yon_motor_surucu
    import yon_pkg::*;
#(
    parameter int KARARLI_SAYI = 4,
    parameter int OLU_ZAMAN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       etkin,
    input  logic       yon_solbit,
    input  logic       yon_sagbit,
    output logic       sol_ileri,
    output logic       sol_geri,
    output logic       sag_ileri,
    output logic       sag_geri,
    output logic [1:0] aktif_yon,
    output logic       mesgul
);

    localparam int FW = (OLU_ZAMAN > 1) ? $clog2(OLU_ZAMAN) : 1;
    localparam logic [FW-1:0] FREN_YUK = FW'(OLU_ZAMAN - 1);

    durum_t        durum, durum_d;
    logic [1:0]    aktif_d;
    logic [FW-1:0] fren_sayac, fren_d;
    logic [1:0]    aday;
    logic          kararli;
    logic [3:0]    motor;

    yon_kararlilik_filtresi #(
        .KARARLI_SAYI(KARARLI_SAYI)
    ) u_filtre (
        .clk    (clk),
        .rst    (rst),
        .yon    ({yon_solbit, yon_sagbit}),
        .aday   (aday),
        .kararli(kararli)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            durum      <= DUR;
            aktif_yon  <= YON_DUZ;
            fren_sayac <= '0;
        end else begin
            durum      <= durum_d;
            aktif_yon  <= aktif_d;
            fren_sayac <= fren_d;
        end
    end

    always_comb begin
        durum_d = durum;
        aktif_d = aktif_yon;
        fren_d  = fren_sayac;
        unique case (durum)
            DUR: begin
                if (etkin && kararli) begin
                    aktif_d = aday;
                    durum_d = SUR;
                end
            end
            SUR: begin
                if (!etkin || (kararli && aday != aktif_yon)) begin
                    durum_d = FREN;
                    fren_d  = FREN_YUK;
                end
            end
            FREN: begin
                // brake always runs to completion; newest stable code wins
                if (fren_sayac == '0) begin
                    if (etkin && kararli) begin
                        aktif_d = aday;
                        durum_d = SUR;
                    end else begin
                        durum_d = DUR;
                    end
                end else begin
                    fren_d = fren_sayac - 1'b1;
                end
            end
            default: durum_d = DUR;
        endcase
    end

    assign motor = (durum == SUR) ? motor_coz(aktif_yon) : 4'b0000;
    assign {sol_ileri, sol_geri, sag_ileri, sag_geri} = motor;
    assign mesgul = (durum == FREN);

    a_ust_uste: assert property (@(posedge clk)
        !(sol_ileri && sol_geri) && !(sag_ileri && sag_geri));

endmodule

// File: tb/tb_yon_motor_surucu.sv
// tb_yon_motor_surucu: vector table, hand-written corner
// sequences and random stimulus against a reference model.
module tb_yon_motor_surucu;

    localparam int K = 4;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       etkin = 1'b0;
    logic [1:0] yon = 2'b00;
    logic       sol_ileri, sol_geri, sag_ileri, sag_geri;
    logic [1:0] aktif_yon;
    logic       mesgul;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    yon_motor_surucu #(
        .KARARLI_SAYI(K),
        .OLU_ZAMAN   (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .etkin     (etkin),
        .yon_solbit(yon[1]),
        .yon_sagbit(yon[0]),
        .sol_ileri (sol_ileri),
        .sol_geri  (sol_geri),
        .sag_ileri (sag_ileri),
        .sag_geri  (sag_geri),
        .aktif_yon (aktif_yon),
        .mesgul    (mesgul)
    );

    // reference model: sample history plus remaining brake cycles
    localparam int M_DUR  = 0;
    localparam int M_SUR  = 1;
    localparam int M_FREN = 2;

    logic [1:0] hist[$];
    int         mode = M_DUR;
    logic [1:0] m_aktif = 2'b00;
    int         brake = 0;

    function automatic logic [3:0] ref_motor(int md, logic [1:0] a);
        if (md != M_SUR) return 4'b0000;
        case (a)
            2'b00:   return 4'b1010;
            2'b10:   return 4'b1000;
            2'b01:   return 4'b0010;
            default: return 4'b0101;
        endcase
    endfunction

    function automatic bit stable();
        if (hist.size() < K) return 1'b0;
        for (int i = hist.size() - K; i < hist.size(); i++)
            if (hist[i] != hist[hist.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] ref_obs();
        return {ref_motor(mode, m_aktif), m_aktif, 1'(mode == M_FREN)};
    endfunction

    function automatic logic [6:0] obs();
        return {sol_ileri, sol_geri, sag_ileri, sag_geri, aktif_yon, mesgul};
    endfunction

    task automatic model_step();
        bit         st;
        logic [1:0] ad;
        if (rst) begin
            hist = {};
            hist.push_back(2'b00);
            mode = M_DUR;
            m_aktif = 2'b00;
            brake = 0;
            return;
        end
        st = stable();
        ad = hist[hist.size()-1];
        case (mode)
            M_DUR: begin
                if (etkin && st) begin
                    m_aktif = ad;
                    mode = M_SUR;
                end
            end
            M_SUR: begin
                if (!etkin || (st && ad != m_aktif)) begin
                    mode = M_FREN;
                    brake = D;
                end
            end
            default: begin
                brake--;
                if (brake == 0) begin
                    if (etkin && st) begin
                        m_aktif = ad;
                        mode = M_SUR;
                    end else begin
                        mode = M_DUR;
                    end
                end
            end
        endcase
        hist.push_back(yon);
        if (hist.size() > K) void'(hist.pop_front());
    endtask

    task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", obs(), ref_obs());
        chk("overlap", {6'b0, (sol_ileri && sol_geri) || (sag_ileri && sag_geri)}, 7'b0);
    endtask

    task automatic set(logic r, logic e, logic [1:0] y);
        rst = r;
        etkin = e;
        yon = y;
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [1:0] y;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[23];

    initial begin
        int len;
        tbl[0] = '{1'b1, 1'b0, 2'b00, 7'b0000_00_0};
        for (int i = 1; i <= 3; i++) tbl[i] = '{1'b0, 1'b1, 2'b00, 7'b0000_00_0};
        tbl[4] = '{1'b0, 1'b1, 2'b00, 7'b1010_00_0};
        for (int i = 5; i <= 7; i++) tbl[i] = '{1'b0, 1'b1, 2'b11, 7'b1010_00_0};
        for (int i = 8; i <= 9; i++) tbl[i] = '{1'b0, 1'b1, 2'b00, 7'b1010_00_0};
        for (int i = 10; i <= 13; i++) tbl[i] = '{1'b0, 1'b1, 2'b11, 7'b1010_00_0};
        for (int i = 14; i <= 21; i++) tbl[i] = '{1'b0, 1'b1, 2'b11, 7'b0000_00_1};
        tbl[22] = '{1'b0, 1'b1, 2'b11, 7'b0101_11_0};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            set(tbl[i].r, tbl[i].e, tbl[i].y);
            tick();
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // code changes mid-brake: newest stable code is taken at exit
        set(1'b1, 1'b1, 2'b00);
        tick();
        set(1'b0, 1'b1, 2'b00);
        repeat (4) tick();
        chk("t4_sur00", obs(), 7'b1010_00_0);
        yon = 2'b11;
        repeat (4) tick();
        chk("t4_pre", obs(), 7'b1010_00_0);
        tick();
        chk("t4_fren", obs(), 7'b0000_00_1);
        tick();
        yon = 2'b10;
        repeat (6) tick();
        chk("t4_hold", obs(), 7'b0000_00_1);
        tick();
        chk("t4_exit", obs(), 7'b1000_10_0);

        // disable: full brake, then stop, then restart
        set(1'b0, 1'b0, 2'b10);
        tick();
        chk("t5_fren", obs(), 7'b0000_10_1);
        repeat (7) tick();
        chk("t5_last", obs(), 7'b0000_10_1);
        tick();
        chk("t5_dur", obs(), 7'b0000_10_0);
        etkin = 1'b1;
        tick();
        chk("t5_sur", obs(), 7'b1000_10_0);

        // reset in the middle of a brake
        set(1'b0, 1'b0, 2'b10);
        tick();
        chk("t6_fren", obs(), 7'b0000_10_1);
        etkin = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t6_rst", obs(), 7'b0000_00_0);
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            yon = 2'($urandom_range(0, 3));
            etkin = ($urandom_range(0, 99) < 85);
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 199) == 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
